// File: rtl/master_port.sv
// rtl/master_port.sv - Serial system-bus initiator: parallel request to serial req/addr/data with split and timeout.
// Outputs are registered from the next-state decode so each serial bit lands exactly one cycle after its transition.
module master_port #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        d_start,
  input  logic        d_write,
  input  logic [11:0] d_address,
  input  logic [3:0]  d_burst_len,
  input  logic [7:0]  d_wdata,
  output logic        d_busy,
  output logic        d_wready,
  output logic [7:0]  d_rdata,
  output logic        d_rvalid,
  output logic        d_done,
  output logic        d_error,
  output logic        read_enable,
  output logic        write_enable,
  output logic        m_valid,
  output logic        m_ready,
  output logic        tx_address,
  output logic        tx_burst,
  output logic        tx_data,
  input  logic        s_ready,
  input  logic        s_valid,
  input  logic        rx_data,
  input  logic        split_enable
);

  typedef enum logic [2:0] {
    IDLE, REQ, ADDR, WDATA_WAIT, WDATA, RDATA_WAIT, RDATA, SPLIT
  } state_e;

  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  logic [3:0]  bit_q, bit_d;
  logic [3:0]  beat_q, beat_d;
  logic [7:0]  tmo_q, tmo_d;
  logic [11:0] addr_q, addr_d;
  logic [3:0]  burst_q, burst_d;
  logic        write_q, write_d;
  logic [7:0]  wdata_q, wdata_d;
  logic [7:0]  rsh_q, rsh_d;

  logic        busy_q, busy_d;
  logic [7:0]  rdata_q, rdata_d;
  logic        rvalid_q, rvalid_d;
  logic        done_q, done_d;
  logic        error_q, error_d;
  logic        ren_q, ren_d;
  logic        wen_q, wen_d;
  logic        mvalid_q, mvalid_d;
  logic        mready_q, mready_d;
  logic        txa_q, txa_d;
  logic        txb_q, txb_d;
  logic        txd_q, txd_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= IDLE;
      bit_q    <= '0;
      beat_q   <= '0;
      tmo_q    <= '0;
      addr_q   <= '0;
      burst_q  <= '0;
      write_q  <= 1'b0;
      wdata_q  <= '0;
      rsh_q    <= '0;
      busy_q   <= 1'b0;
      rdata_q  <= '0;
      rvalid_q <= 1'b0;
      done_q   <= 1'b0;
      error_q  <= 1'b0;
      ren_q    <= 1'b0;
      wen_q    <= 1'b0;
      mvalid_q <= 1'b0;
      mready_q <= 1'b0;
      txa_q    <= 1'b0;
      txb_q    <= 1'b0;
      txd_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      bit_q    <= bit_d;
      beat_q   <= beat_d;
      tmo_q    <= tmo_d;
      addr_q   <= addr_d;
      burst_q  <= burst_d;
      write_q  <= write_d;
      wdata_q  <= wdata_d;
      rsh_q    <= rsh_d;
      busy_q   <= busy_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      done_q   <= done_d;
      error_q  <= error_d;
      ren_q    <= ren_d;
      wen_q    <= wen_d;
      mvalid_q <= mvalid_d;
      mready_q <= mready_d;
      txa_q    <= txa_d;
      txb_q    <= txb_d;
      txd_q    <= txd_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    bit_d    = bit_q;
    beat_d   = beat_q;
    tmo_d    = tmo_q;
    addr_d   = addr_q;
    burst_d  = burst_q;
    write_d  = write_q;
    wdata_d  = wdata_q;
    rsh_d    = rsh_q;
    rdata_d  = rdata_q;
    rvalid_d = 1'b0;
    done_d   = 1'b0;
    error_d  = 1'b0;

    case (state_q)
      IDLE: begin
        if (d_start) begin
          addr_d  = d_address;
          burst_d = d_burst_len;
          beat_d  = d_burst_len;
          write_d = d_write;
          tmo_d   = '0;
          state_d = REQ;
        end
      end
      REQ: begin
        if (s_ready) begin
          bit_d   = '0;
          state_d = ADDR;
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      ADDR: begin
        if (bit_q == 4'd11) begin
          bit_d   = '0;
          tmo_d   = '0;
          state_d = write_q ? WDATA_WAIT : RDATA_WAIT;
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end
      WDATA_WAIT: begin
        if (s_ready) begin
          wdata_d = d_wdata;
          bit_d   = '0;
          state_d = WDATA;
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      WDATA: begin
        if (bit_q == 4'd7) begin
          if (beat_q == 4'd0) begin
            state_d = IDLE;
            done_d  = 1'b1;
          end else begin
            beat_d  = beat_q - 4'd1;
            tmo_d   = '0;
            state_d = WDATA_WAIT;
          end
        end else begin
          bit_d = bit_q + 4'd1;
        end
      end
      RDATA_WAIT: begin
        // Split wins over a simultaneous s_valid so the slave can always reclaim the bus.
        if (split_enable) begin
          state_d = SPLIT;
        end else if (s_valid) begin
          rsh_d   = {rx_data, rsh_q[7:1]};
          bit_d   = 4'd1;
          state_d = RDATA;
        end else if (tmo_q == TMO_LAST) begin
          state_d = IDLE;
          done_d  = 1'b1;
          error_d = 1'b1;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
      end
      RDATA: begin
        if (s_valid) begin
          if (bit_q == 4'd7) begin
            rdata_d  = {rx_data, rsh_q[7:1]};
            rvalid_d = 1'b1;
            if (beat_q == 4'd0) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              beat_d  = beat_q - 4'd1;
              tmo_d   = '0;
              state_d = RDATA_WAIT;
            end
          end else begin
            rsh_d = {rx_data, rsh_q[7:1]};
            bit_d = bit_q + 4'd1;
          end
        end
      end
      SPLIT: begin
        if (!split_enable) begin
          tmo_d   = '0;
          state_d = RDATA_WAIT;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d   = (state_d != IDLE);
    wen_d    = write_d && (state_d inside {REQ, ADDR, WDATA_WAIT, WDATA});
    ren_d    = !write_d && (state_d inside {REQ, ADDR, RDATA_WAIT, RDATA});
    mvalid_d = (state_d inside {REQ, ADDR, WDATA});
    mready_d = (state_d inside {RDATA_WAIT, RDATA});
    txa_d    = (state_d == ADDR) ? addr_d[bit_d] : 1'b0;
    txb_d    = ((state_d == ADDR) && (bit_d < 4'd4)) ? burst_d[bit_d[1:0]] : 1'b0;
    txd_d    = (state_d == WDATA) ? wdata_d[bit_d[2:0]] : 1'b0;
  end

  assign d_busy       = busy_q;
  assign d_wready     = (state_q == WDATA_WAIT);
  assign d_rdata      = rdata_q;
  assign d_rvalid     = rvalid_q;
  assign d_done       = done_q;
  assign d_error      = error_q;
  assign read_enable  = ren_q;
  assign write_enable = wen_q;
  assign m_valid      = mvalid_q;
  assign m_ready      = mready_q;
  assign tx_address   = txa_q;
  assign tx_burst     = txb_q;
  assign tx_data      = txd_q;

endmodule

// File: tb/tb_master_port.sv
// tb/tb_master_port.sv - Scoreboard bench for master_port: directed write/read/split/timeout/reset vectors.
module tb_master_port;

  logic        clk;
  logic        reset;
  logic        d_start;
  logic        d_write;
  logic [11:0] d_address;
  logic [3:0]  d_burst_len;
  logic [7:0]  d_wdata;
  logic        d_busy;
  logic        d_wready;
  logic [7:0]  d_rdata;
  logic        d_rvalid;
  logic        d_done;
  logic        d_error;
  logic        read_enable;
  logic        write_enable;
  logic        m_valid;
  logic        m_ready;
  logic        tx_address;
  logic        tx_burst;
  logic        tx_data;
  logic        s_ready;
  logic        s_valid;
  logic        rx_data;
  logic        split_enable;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic       is_done;
    logic       err;
    logic [7:0] data;
  } exp_t;

  exp_t sb[$];

  master_port #(.TIMEOUT(16)) dut (
    .clk          (clk),
    .reset        (reset),
    .d_start      (d_start),
    .d_write      (d_write),
    .d_address    (d_address),
    .d_burst_len  (d_burst_len),
    .d_wdata      (d_wdata),
    .d_busy       (d_busy),
    .d_wready     (d_wready),
    .d_rdata      (d_rdata),
    .d_rvalid     (d_rvalid),
    .d_done       (d_done),
    .d_error      (d_error),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .m_valid      (m_valid),
    .m_ready      (m_ready),
    .tx_address   (tx_address),
    .tx_burst     (tx_burst),
    .tx_data      (tx_data),
    .s_ready      (s_ready),
    .s_valid      (s_valid),
    .rx_data      (rx_data),
    .split_enable (split_enable)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic push_exp(input logic is_done, input logic err, input logic [7:0] data);
    exp_t e;
    e.is_done = is_done;
    e.err     = err;
    e.data    = data;
    sb.push_back(e);
  endtask

  // Response monitor: every d_rvalid / d_done pulse must match the next queued expectation.
  always @(negedge clk) begin : mon
    exp_t e;
    if (d_rvalid) begin
      if (sb.size() == 0) chk("rvalid_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        chk("rvalid_order", e.is_done, 0);
        chk("rdata", d_rdata, e.data);
      end
    end
    if (d_done) begin
      if (sb.size() == 0) chk("done_unexpected", 1, 0);
      else begin
        e = sb.pop_front();
        chk("done_order", e.is_done, 1);
        chk("done_error", d_error, e.err);
      end
    end
    if (d_error && !d_done) chk("error_without_done", 1, 0);
  end

  task automatic do_write(input logic [11:0] a, input logic [3:0] bl,
                          input logic [7:0] d0, input logic [7:0] d1,
                          input logic [0:11] ea, input logic [0:11] eb,
                          input logic [0:7] e0, input logic [0:7] e1,
                          input bit poke);
    logic [0:11] ca;
    logic [0:11] cb;
    logic [0:7]  cd;
    push_exp(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    d_start = 1'b1; d_write = 1'b1; d_address = a; d_burst_len = bl;
    d_wdata = d0; s_ready = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    chk("wr_req_busy", d_busy, 1);
    chk("wr_req_wen", write_enable, 1);
    chk("wr_req_ren", read_enable, 0);
    chk("wr_req_mvalid", m_valid, 1);
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      ca[i] = tx_address;
      cb[i] = tx_burst;
      if (poke && i == 3) begin
        d_start = 1'b1; d_write = 1'b0; d_address = 12'hFFF; d_burst_len = 4'hF;
      end else begin
        d_start = 1'b0;
      end
    end
    chk("wr_addr_serial", ca, ea);
    chk("wr_burst_serial", cb, eb);
    for (int b = 0; b <= int'(bl); b++) begin
      @(negedge clk);
      chk("wr_wready", d_wready, 1);
      chk("wr_wait_mvalid", m_valid, 0);
      chk("wr_wait_wen", write_enable, 1);
      for (int i = 0; i < 8; i++) begin
        @(negedge clk);
        cd[i] = tx_data;
      end
      chk("wr_data_serial", cd, (b == 0) ? e0 : e1);
      d_wdata = d1;
    end
    @(negedge clk);
    chk("wr_done_timing", d_done, 1);
    chk("wr_done_busy", d_busy, 0);
    chk("wr_done_wen", write_enable, 0);
    s_ready = 1'b0;
    d_write = 1'b0;
  endtask

  task automatic send_byte(input logic [7:0] v, input bit last);
    s_valid = 1'b1;
    rx_data = v[0];
    for (int i = 1; i < 8; i++) begin
      @(negedge clk);
      rx_data = v[i];
    end
    @(negedge clk);
    s_valid = 1'b0;
    rx_data = 1'b0;
    chk("rd_rvalid_timing", d_rvalid, 1);
    chk("rd_busy_after_beat", d_busy, last ? 0 : 1);
  endtask

  task automatic do_read(input logic [11:0] a, input logic [3:0] bl, input int dly,
                         input logic [31:0] data, input int split_beat);
    for (int b = 0; b <= int'(bl); b++) push_exp(1'b0, 1'b0, data[b*8 +: 8]);
    push_exp(1'b1, 1'b0, 8'h00);
    @(negedge clk);
    d_start = 1'b1; d_write = 1'b0; d_address = a; d_burst_len = bl; s_ready = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    chk("rd_req_ren", read_enable, 1);
    chk("rd_req_wen", write_enable, 0);
    chk("rd_req_mvalid", m_valid, 1);
    repeat (12) @(negedge clk);
    s_ready = 1'b0;
    @(negedge clk);
    chk("rd_wait_mready", m_ready, 1);
    chk("rd_wait_ren", read_enable, 1);
    chk("rd_wait_mvalid", m_valid, 0);
    for (int b = 0; b <= int'(bl); b++) begin
      if (b == split_beat) begin
        split_enable = 1'b1;
        @(negedge clk);
        chk("split_ren", read_enable, 0);
        chk("split_mready", m_ready, 0);
        chk("split_busy", d_busy, 1);
        repeat (19) @(negedge clk);
        chk("split_ren_late", read_enable, 0);
        split_enable = 1'b0;
        @(negedge clk);
        chk("resume_ren", read_enable, 1);
        chk("resume_mready", m_ready, 1);
      end
      repeat (dly) @(negedge clk);
      send_byte(data[b*8 +: 8], b == int'(bl));
    end
  endtask

  initial begin
    reset = 1'b0;
    d_start = 1'b0; d_write = 1'b0; d_address = '0; d_burst_len = '0; d_wdata = '0;
    s_ready = 1'b0; s_valid = 1'b0; rx_data = 1'b0; split_enable = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", d_busy, 0);
    chk("rst_rdata", d_rdata, 0);
    chk("rst_pulses", {d_rvalid, d_done, d_error}, 0);
    chk("rst_bus", {read_enable, write_enable, m_valid, m_ready, d_wready}, 0);
    chk("rst_tx", {tx_address, tx_burst, tx_data}, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // Write 0xA5 to 0x3C1, single beat.
    do_write(12'h3C1, 4'd0, 8'hA5, 8'h00,
             12'b100000111100, 12'b000000000000, 8'b10100101, 8'b00000000, 1'b0);
    repeat (2) @(negedge clk);

    // Read 0x5A from 0x010 after a 5-cycle s_valid delay.
    do_read(12'h010, 4'd0, 5, 32'h0000005A, -1);
    repeat (2) @(negedge clk);

    // Four-beat read with a 20-cycle split before beat 2.
    do_read(12'h2A7, 4'd3, 2, 32'h7E81C33C, 2);
    repeat (2) @(negedge clk);

    // Write with s_ready never asserted: timeout after 16 cycles in REQ.
    push_exp(1'b1, 1'b1, 8'h00);
    @(negedge clk);
    d_start = 1'b1; d_write = 1'b1; d_address = 12'h155; d_burst_len = 4'd0; s_ready = 1'b0;
    @(negedge clk);
    d_start = 1'b0;
    chk("tmo_req_wen", write_enable, 1);
    repeat (15) @(negedge clk);
    chk("tmo_not_yet", d_done, 0);
    chk("tmo_wen_still", write_enable, 1);
    @(negedge clk);
    chk("tmo_done", d_done, 1);
    chk("tmo_error", d_error, 1);
    chk("tmo_bus_idle", {write_enable, read_enable, m_valid, m_ready, d_busy}, 0);
    repeat (2) @(negedge clk);

    // Reset during ADDR bit 6 aborts without d_done.
    @(negedge clk);
    d_start = 1'b1; d_write = 1'b1; d_address = 12'h3C1; d_burst_len = 4'd0;
    d_wdata = 8'hA5; s_ready = 1'b1;
    @(negedge clk);
    d_start = 1'b0;
    repeat (7) @(negedge clk);
    chk("pre_rst_addr_bit6", tx_address, 1);
    chk("pre_rst_wen", write_enable, 1);
    reset = 1'b0;
    #1;
    chk("rst_async_bus", {write_enable, m_valid, d_busy, tx_address, tx_burst}, 0);
    s_ready = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_no_done", d_done, 0);
    reset = 1'b1;
    repeat (2) @(negedge clk);

    // New two-beat write after reset; a d_start during the transfer is ignored.
    do_write(12'h812, 4'd1, 8'h6C, 8'hF1,
             12'b010010000001, 12'b100000000000, 8'b00110110, 8'b10001111, 1'b1);
    repeat (4) @(negedge clk);
    chk("poke_ignored_idle", d_busy, 0);
    chk("scoreboard_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
